// File: rtl/switch_pkg.sv
// Shared definitions for the switch input controller: read-select codes and status layout.
package switch_pkg;

  typedef enum logic [1:0] {
    SEL_LANE0  = 2'd0,
    SEL_LANE1  = 2'd1,
    SEL_STATUS = 2'd2,
    SEL_RAW    = 2'd3
  } rd_sel_e;

  localparam int STATUS_CHANGED_BIT = 0;

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus a single shared stability counter that accepts a new
// switch vector once it has been unchanged for DB_CYCLES cycles.
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int W         = 24,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sw_raw,
  output logic [W-1:0] sw_sync,
  output logic [W-1:0] sw_stable,
  output logic         accept
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [W-1:0]     s1_q, s2_q, prev_q;
  logic [W-1:0]     stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A change on any bit restarts the window for the whole vector.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    accept   = 1'b0;
    if (s2_q != prev_q) begin
      cnt_d = '0;
    end else if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = s2_q;
      cnt_d    = '0;
      accept   = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      prev_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= sw_raw;
      s2_q     <= s1_q;
      prev_q   <= s2_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sw_sync   = s2_q;
  assign sw_stable = stable_q;

endmodule

// File: rtl/switch_input_ctrl.sv
// Board-switch input controller: debounced lanes, registered read port and a sticky
// change flag. Define SWITCH_IRQ_EN to build the registered change interrupt.
module switch_input_ctrl
  import switch_pkg::*;
#(
  parameter int SW_WIDTH   = 24,
  parameter int DATA_WIDTH = 16,
  parameter int DB_CYCLES  = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SW_WIDTH-1:0]   sw_raw,
  input  logic                  rd_en,
  input  logic [1:0]            rd_sel,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [SW_WIDTH-1:0]   sw_stable,
  output logic                  irq
);

  logic [SW_WIDTH-1:0]   sw_sync;
  logic                  accept;
  logic [DATA_WIDTH-1:0] lane0, lane1, raw0, status_word;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  changed_q, changed_d;
  logic                  status_clr;

  switch_debouncer #(
    .W        (SW_WIDTH),
    .DB_CYCLES(DB_CYCLES)
  ) u_debouncer (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_raw   (sw_raw),
    .sw_sync  (sw_sync),
    .sw_stable(sw_stable),
    .accept   (accept)
  );

  generate
    if (SW_WIDTH > DATA_WIDTH) begin : g_wide
      logic unused_sync_hi;
      assign lane0          = sw_stable[DATA_WIDTH-1:0];
      assign lane1          = DATA_WIDTH'(sw_stable[SW_WIDTH-1:DATA_WIDTH]);
      assign raw0           = sw_sync[DATA_WIDTH-1:0];
      assign unused_sync_hi = ^sw_sync[SW_WIDTH-1:DATA_WIDTH];
    end else begin : g_narrow
      assign lane0 = DATA_WIDTH'(sw_stable);
      assign lane1 = '0;
      assign raw0  = DATA_WIDTH'(sw_sync);
    end
  endgenerate

  assign status_clr = rd_en && (rd_sel == SEL_STATUS);

  // Status reads return the flag as it stood before this cycle; a set wins over a clear.
  always_comb begin
    status_word                     = '0;
    status_word[STATUS_CHANGED_BIT] = changed_q;

    changed_d = changed_q;
    if (accept) begin
      changed_d = 1'b1;
    end else if (status_clr) begin
      changed_d = 1'b0;
    end

    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    if (rd_en) begin
      case (rd_sel_e'(rd_sel))
        SEL_LANE0:  rd_data_d = lane0;
        SEL_LANE1:  rd_data_d = lane1;
        SEL_STATUS: rd_data_d = status_word;
        SEL_RAW:    rd_data_d = raw0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      changed_q  <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      changed_q  <= changed_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

`ifdef SWITCH_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = changed_q & ~(status_clr & ~accept);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_switch_input_ctrl.sv
// Bench for switch_input_ctrl: directed scenarios then random switch/read traffic,
// checked every cycle against a run-length reference model.
module tb_switch_input_ctrl;

  localparam int SW = 24;
  localparam int DW = 16;
  localparam int DB = 4;

  logic          clk;
  logic          rst_n;
  logic [SW-1:0] sw_raw;
  logic          rd_en;
  logic [1:0]    rd_sel;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [SW-1:0] sw_stable;
  logic          irq;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: a two-deep delay line for the synchroniser and the
  // length of the current run of identical synchronised samples.
  logic [SW-1:0] pipe[$];
  logic [SW-1:0] m_stable, m_last;
  int            m_run;
  logic          m_changed, m_irq, m_valid;
  logic [DW-1:0] m_data;

  switch_input_ctrl #(
    .SW_WIDTH  (SW),
    .DATA_WIDTH(DW),
    .DB_CYCLES (DB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_raw   (sw_raw),
    .rd_en    (rd_en),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .sw_stable(sw_stable),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    pipe = {};
    pipe.push_back('0);
    pipe.push_back('0);
    m_stable  = '0;
    m_last    = '0;
    m_run     = 0;
    m_changed = 1'b0;
    m_irq     = 1'b0;
    m_valid   = 1'b0;
    m_data    = '0;
  endtask

  task automatic modelEdge(input logic [SW-1:0] raw, input logic en, input logic [1:0] sel);
    logic [SW-1:0] s2;
    logic          acc, clr;
    s2  = pipe[0];
    acc = 1'b0;
    clr = en && (sel == 2'd2);
    if (s2 !== m_last) m_run = 1;
    else m_run++;
    m_last  = s2;
    m_valid = en;
    if (en) begin
      case (sel)
        2'd0:    m_data = m_stable[15:0];
        2'd1:    m_data = {8'h00, m_stable[23:16]};
        2'd2:    m_data = {15'h0000, m_changed};
        default: m_data = s2[15:0];
      endcase
    end
    if (s2 != m_stable && m_run >= DB + 1) begin
      m_stable = s2;
      acc      = 1'b1;
    end
`ifdef SWITCH_IRQ_EN
    m_irq = m_changed && !(clr && !acc);
`endif
    if (acc) m_changed = 1'b1;
    else if (clr) m_changed = 1'b0;
    void'(pipe.pop_front());
    pipe.push_back(raw);
  endtask

  task automatic checkOutput(input string tag);
    checkVal($sformatf("%s.sw_stable", tag), 32'(sw_stable), 32'(m_stable));
    checkVal($sformatf("%s.rd_valid", tag), 32'(rd_valid), 32'(m_valid));
    checkVal($sformatf("%s.rd_data", tag), 32'(rd_data), 32'(m_data));
    checkVal($sformatf("%s.irq", tag), 32'(irq), 32'(m_irq));
  endtask

  task automatic applyStimulus(input logic [SW-1:0] raw, input logic en, input logic [1:0] sel,
                               input string tag);
    sw_raw = raw;
    rd_en  = en;
    rd_sel = sel;
    @(posedge clk);
    modelEdge(raw, en, sel);
    #1;
    checkOutput(tag);
  endtask

  task automatic doReset(input logic [SW-1:0] raw, input int cycles, input string tag);
    sw_raw = raw;
    rd_en  = 1'b0;
    rd_sel = 2'd0;
    rst_n  = 1'b0;
    #1;
    modelReset();
    checkOutput(tag);
    repeat (cycles) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    logic [SW-1:0] raw_cur;
    logic [SW-1:0] r;
    int            hold;

    rst_n  = 1'b0;
    sw_raw = '0;
    rd_en  = 1'b0;
    rd_sel = 2'd0;

    $display("[TB] reset and first acceptance");
    doReset(24'hFFFFFF, 3, "t1.reset");
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(24'hFFFFFF, 1'b0, 2'd0, "t1.accept");
      if (i == 6) checkVal("t1.not_yet", 32'(sw_stable), 32'h0);
    end
    checkVal("t1.cycle7", 32'(sw_stable), 32'hFFFFFF);

    $display("[TB] status read clears changed");
    applyStimulus(24'hFFFFFF, 1'b1, 2'd2, "t4.read1");
    checkVal("t4.status1", 32'(rd_data), 32'h1);
    applyStimulus(24'hFFFFFF, 1'b1, 2'd2, "t4.read2");
    checkVal("t4.status2", 32'(rd_data), 32'h0);

    $display("[TB] bounce rejection");
    doReset(24'h0, 2, "t2.reset");
    for (int i = 0; i < 10; i++) begin
      repeat (2) begin
        applyStimulus((i % 2 == 0) ? 24'h000001 : 24'h000000, 1'b0, 2'd0, "t2.bounce");
        checkVal("t2.held", 32'(sw_stable), 32'h0);
      end
    end
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(24'h000001, 1'b0, 2'd0, "t2.settle");
      if (i == 6) checkVal("t2.not_yet", 32'(sw_stable), 32'h0);
    end
    checkVal("t2.accept", 32'(sw_stable), 32'h000001);

    $display("[TB] lane reads");
    repeat (8) applyStimulus(24'hA5C37E, 1'b0, 2'd0, "t3.load");
    checkVal("t3.stable", 32'(sw_stable), 32'hA5C37E);
    applyStimulus(24'hA5C37E, 1'b1, 2'd0, "t3.sel0");
    checkVal("t3.lane0", 32'(rd_data), 32'hC37E);
    checkVal("t3.valid0", 32'(rd_valid), 32'h1);
    applyStimulus(24'hA5C37E, 1'b1, 2'd1, "t3.sel1");
    checkVal("t3.lane1", 32'(rd_data), 32'h00A5);
    applyStimulus(24'hA5C37E, 1'b0, 2'd0, "t3.idle");
    checkVal("t3.valid_low", 32'(rd_valid), 32'h0);
    checkVal("t3.hold", 32'(rd_data), 32'h00A5);
    applyStimulus(24'hA5C37E, 1'b1, 2'd3, "t3.sel3");
    checkVal("t3.raw", 32'(rd_data), 32'hC37E);

    $display("[TB] set/clear collision");
    applyStimulus(24'hA5C37E, 1'b1, 2'd2, "t5.preclear");
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(24'h000000, (i == 7), 2'd2, "t5.window");
    end
    checkVal("t5.coll_data", 32'(rd_data), 32'h0);
    checkVal("t5.coll_stable", 32'(sw_stable), 32'h0);
`ifdef SWITCH_IRQ_EN
    checkVal("t5.irq_before", 32'(irq), 32'h0);
`endif
    applyStimulus(24'h000000, 1'b0, 2'd0, "t5.idle");
`ifdef SWITCH_IRQ_EN
    checkVal("t5.irq_up", 32'(irq), 32'h1);
`endif
    applyStimulus(24'h000000, 1'b1, 2'd2, "t5.read");
    checkVal("t5.set_won", 32'(rd_data), 32'h1);
`ifdef SWITCH_IRQ_EN
    checkVal("t5.irq_down", 32'(irq), 32'h0);
`endif
    applyStimulus(24'h000000, 1'b1, 2'd2, "t5.reread");
    checkVal("t5.cleared", 32'(rd_data), 32'h0);

    $display("[TB] async reset mid-window");
    applyStimulus(24'h000000, 1'b1, 2'd3, "t6.prime");
    repeat (5) applyStimulus(24'h123456, 1'b0, 2'd0, "t6.count");
    #2;
    doReset(24'h000000, 2, "t6.reset");
    checkVal("t6.stable0", 32'(sw_stable), 32'h0);
    checkVal("t6.valid0", 32'(rd_valid), 32'h0);
    checkVal("t6.data0", 32'(rd_data), 32'h0);
    repeat (10) applyStimulus(24'h000000, 1'b0, 2'd0, "t6.after");
    checkVal("t6.no_accept", 32'(sw_stable), 32'h0);

    $display("[TB] random traffic");
    raw_cur = SW'($urandom);
    doReset(raw_cur, 2, "rand.reset");
    for (int seg = 0; seg < 80; seg++) begin
      case ($urandom_range(0, 2))
        0:       r = SW'($urandom);
        1:       r = raw_cur ^ (24'h000001 << $urandom_range(0, 23));
        default: r = raw_cur;
      endcase
      raw_cur = r;
      hold    = $urandom_range(1, 9);
      for (int k = 0; k < hold; k++) begin
        applyStimulus(r, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), "rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
